// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle main control FSM for the MIPS datapath.
// Sequences fetch, decode, execute, memory and write-back one instruction at
// a time, stalls on the memory-ready handshake and counts retired
// instructions.
// Optional feature: define CONTROLE_ADDI_EN to decode addi (opcode 001000)
// through EXEC_IMED/FIM_IMED. Without it, 001000 is an illegal opcode.
module controle_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        memPronto,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        regDest,
  output logic        regWrite,
  output logic        memToReg,
  output logic        memRead,
  output logic        memWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  PCSource,
  output logic        pcEscreve,
  output logic        excecao,
  output logic [31:0] retiradas
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CONTROLE_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [3:0] {
    BUSCA       = 4'd0,
    DECODIFICA  = 4'd1,
    ENDERECO    = 4'd2,
    LEITURA     = 4'd3,
    ESCREVE_MEM = 4'd4,
    ESCRITA     = 4'd5,
    EXECUTA     = 4'd6,
    FIM_R       = 4'd7,
    DESVIO      = 4'd8,
    SALTO       = 4'd9,
`ifdef CONTROLE_ADDI_EN
    EXEC_IMED   = 4'd10,
    FIM_IMED    = 4'd11,
`endif
    ILEGAL      = 4'd15
  } estado_t;

  estado_t     estado_r;
  estado_t     prox_s;
  logic [5:0]  opcode_r;
  logic        retira_s;

  // Ungated control values decoded from the current state
  logic        alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [1:0]  alu_op_s;
  logic        reg_dest_s;
  logic        reg_write_s;
  logic        mem_to_reg_s;
  logic        mem_read_s;
  logic        mem_write_s;
  logic        iord_s;
  logic        ir_write_s;
  logic [1:0]  pc_source_s;
  logic        pc_write_s;
  logic        pc_write_cond_s;
  logic        excecao_s;

  // State register: reset returns to fetch and abandons any instruction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r <= BUSCA;
    end else begin
      estado_r <= prox_s;
    end
  end

  // Instruction opcode is captured on the fetch completion edge only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode_r <= 6'b000000;
    end else if ((estado_r == BUSCA) && memPronto) begin
      opcode_r <= opcode;
    end else begin
      opcode_r <= opcode_r;
    end
  end

  // Any return to fetch from another state means an instruction completed
  assign retira_s = (estado_r != BUSCA) && (prox_s == BUSCA);

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retiradas <= 32'd0;
    end else if (retira_s) begin
      retiradas <= retiradas + 32'd1;
    end else begin
      retiradas <= retiradas;
    end
  end

  // Next-state logic; decode looks only at the latched opcode
  always_comb begin
    prox_s = estado_r;
    case (estado_r)
      BUSCA: begin
        if (memPronto) begin
          prox_s = DECODIFICA;
        end else begin
          prox_s = BUSCA;
        end
      end
      DECODIFICA: begin
        case (opcode_r)
          OP_LW, OP_SW: prox_s = ENDERECO;
          OP_R:         prox_s = EXECUTA;
          OP_BEQ:       prox_s = DESVIO;
          OP_J:         prox_s = SALTO;
`ifdef CONTROLE_ADDI_EN
          OP_ADDI:      prox_s = EXEC_IMED;
`endif
          default:      prox_s = ILEGAL;
        endcase
      end
      ENDERECO: begin
        if (opcode_r == OP_LW) begin
          prox_s = LEITURA;
        end else begin
          prox_s = ESCRITA;
        end
      end
      LEITURA: begin
        if (memPronto) begin
          prox_s = ESCREVE_MEM;
        end else begin
          prox_s = LEITURA;
        end
      end
      ESCREVE_MEM: prox_s = BUSCA;
      ESCRITA: begin
        if (memPronto) begin
          prox_s = BUSCA;
        end else begin
          prox_s = ESCRITA;
        end
      end
      EXECUTA:     prox_s = FIM_R;
      FIM_R:       prox_s = BUSCA;
      DESVIO:      prox_s = BUSCA;
      SALTO:       prox_s = BUSCA;
`ifdef CONTROLE_ADDI_EN
      EXEC_IMED:   prox_s = FIM_IMED;
      FIM_IMED:    prox_s = BUSCA;
`endif
      ILEGAL:      prox_s = ILEGAL;
      default:     prox_s = ILEGAL;
    endcase
  end

  // Moore control decode; everything not named for a state stays 0
  always_comb begin
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    reg_dest_s      = 1'b0;
    reg_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    iord_s          = 1'b0;
    ir_write_s      = 1'b0;
    pc_source_s     = 2'b00;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    excecao_s       = 1'b0;
    case (estado_r)
      BUSCA: begin
        // PC+4 and IR load complete together with the memory read
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = memPronto;
        pc_write_s  = memPronto;
      end
      DECODIFICA: begin
        // Branch target precomputed into ALUOut
        alu_src_b_s = 2'b11;
      end
      ENDERECO: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      LEITURA: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      ESCREVE_MEM: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      ESCRITA: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      EXECUTA: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      FIM_R: begin
        reg_write_s = 1'b1;
        reg_dest_s  = 1'b1;
      end
      DESVIO: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_source_s     = 2'b01;
        pc_write_cond_s = 1'b1;
      end
      SALTO: begin
        pc_source_s = 2'b10;
        pc_write_s  = 1'b1;
      end
`ifdef CONTROLE_ADDI_EN
      EXEC_IMED: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      FIM_IMED: begin
        reg_write_s = 1'b1;
      end
`endif
      ILEGAL: begin
        excecao_s = 1'b1;
      end
      default: begin
        excecao_s = 1'b1;
      end
    endcase
  end

  // Outputs are forced low combinationally while reset is high so no write
  // enable can glitch between the reset edge and the next clock
  always_comb begin
    if (reset) begin
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      regDest   = 1'b0;
      regWrite  = 1'b0;
      memToReg  = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      PCSource  = 2'b00;
      pcEscreve = 1'b0;
      excecao   = 1'b0;
    end else begin
      ALUSrcA   = alu_src_a_s;
      ALUSrcB   = alu_src_b_s;
      ALUOp     = alu_op_s;
      regDest   = reg_dest_s;
      regWrite  = reg_write_s;
      memToReg  = mem_to_reg_s;
      memRead   = mem_read_s;
      memWrite  = mem_write_s;
      IorD      = iord_s;
      IRWrite   = ir_write_s;
      PCSource  = pc_source_s;
      pcEscreve = pc_write_s | (pc_write_cond_s & zero);
      excecao   = excecao_s;
    end
  end

endmodule
